parity_checker: RTL and testbench
=================================

PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 1..64.
REQ-002 Parameter ODD, default 0; 0 = even parity (parity bit == ^data), 1 = odd parity (parity bit == ~^data).
REQ-003 Parameter CNT_WIDTH, default 8, width of the error counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  WIDTH  received data word.
REQ-009 in_parity  input  1  received parity bit, as produced by the team's Parity generator.
REQ-010 out_valid  output  1  registered output word valid.
REQ-011 out_ready  input  1  downstream accepts output word.
REQ-012 out_data  output  WIDTH  checked data word, passed through unmodified.
REQ-013 out_err  output  1  parity mismatch flag for the word on out_data.
REQ-014 err_sticky  output  1  set on any accepted mismatched word; held until cleared.
REQ-015 err_count  output  CNT_WIDTH  saturating count of accepted mismatched words.
REQ-016 err_clr  input  1  single-cycle clear of err_sticky and err_count.

Function
REQ-017 The block SHALL accept an input word on any cycle where in_valid && in_ready (accept event).
REQ-018 The block SHALL compute expected = (^in_data) ^ ODD and mismatch = (in_parity != expected) combinationally on the input word.
REQ-019 The block SHALL be a single registered output stage: on accept, out_data <= in_data, out_err <= mismatch, out_valid <= 1 on the next rising edge (latency 1 cycle).
REQ-020 in_ready SHALL equal (!out_valid || out_ready), giving full throughput of one word per cycle under continuous out_ready.
REQ-021 When out_valid && out_ready and no accept occurs in the same cycle, out_valid SHALL clear on the next edge.
REQ-022 When out_valid && !out_ready, out_data, out_err and out_valid SHALL hold stable, and in_ready SHALL be 0.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 On each accept with mismatch = 1, err_count SHALL increment by 1 and SHALL saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-025 On each accept with mismatch = 1, err_sticky SHALL be set to 1.
REQ-026 err_clr without a mismatched accept in the same cycle SHALL set err_count to 0 and err_sticky to 0 on the next edge.
REQ-027 err_clr coinciding with a mismatched accept SHALL result in err_count = 1 and err_sticky = 1 (error is never lost).
REQ-028 err_clr SHALL NOT affect out_valid, out_data or out_err.
REQ-029 Words with mismatch = 1 SHALL still be forwarded; the block flags errors and never drops them.

Reset
REQ-030 While rst = 1, out_valid, out_err, err_sticky SHALL be 0 and err_count SHALL be 0 on the next edge; out_data SHALL be 0.
REQ-031 rst SHALL take priority over accept and err_clr in the same cycle; a word presented during reset SHALL be discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-stream with out_valid = 1 and out_ready = 0 SHALL discard the held word.

Verification
REQ-034 Even parity, WIDTH=8: in_data=8'hAA, in_parity=0, out_ready=1 -> next cycle out_valid=1, out_data=8'hAA, out_err=0, err_count=0.
REQ-035 Even parity: in_data=8'hAB, in_parity=0 -> out_err=1, err_sticky=1, err_count=1; ODD=1 with in_data=8'hAB, in_parity=0 -> out_err=0.
REQ-036 Backpressure: stream 8'h01..8'h05 with out_ready low for 3 cycles after first word -> in_ready=0 during stall, output holds 8'h01, all five words delivered in order, none duplicated.
REQ-037 Saturation, CNT_WIDTH=2: 5 consecutive mismatched words -> err_count sequence 1,2,3,3,3.
REQ-038 err_clr coinciding with a mismatched accept while err_count=3 -> err_count=1, err_sticky=1; err_clr alone -> err_count=0, err_sticky=0.
REQ-039 rst pulse while out_valid=1 and out_ready=0 -> out_valid=0, err_count=0, err_sticky=0 the following cycle; in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/parity_checker_if.sv
// Handshake and status bundle for the parity checker: upstream word in, checked word out, error status.
interface parity_checker_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_parity;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic                 err_sticky;
    logic [CNT_WIDTH-1:0] err_count;
    logic                 err_clr;

    modport master (
        output in_valid, in_data, in_parity, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_err, err_sticky, err_count
    );

    modport slave (
        input  in_valid, in_data, in_parity, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_err, err_sticky, err_count
    );
endinterface

// File: rtl/parity_checker.sv
// Single-stage registered parity checker: forwards every word with a mismatch flag and keeps
// a sticky error bit plus a saturating error counter.
module parity_checker #(
    parameter int WIDTH     = 8,
    parameter int ODD       = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    parity_checker_if.slave bus
);
    localparam logic                 ODD_BIT = (ODD != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_data_r;
    logic                 out_err_r;
    logic                 err_sticky_r;
    logic [CNT_WIDTH-1:0] err_count_r;

    logic ready_s;
    logic accept_s;
    logic mismatch_s;

    // Handshake and parity evaluation; ready looks only at the output stage, never at in_valid.
    always_comb begin
        ready_s    = 1'b0;
        accept_s   = 1'b0;
        mismatch_s = 1'b0;
        ready_s    = !out_valid_r || bus.out_ready;
        accept_s   = bus.in_valid && ready_s;
        mismatch_s = bus.in_parity != (parity_of(bus.in_data) ^ ODD_BIT);
    end

    // Output stage and error status; a mismatched accept outranks a clear so no error is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= bus.in_data;
                out_err_r   <= mismatch_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end

            if (accept_s && mismatch_s) begin
                err_sticky_r <= 1'b1;
                if (bus.err_clr) begin
                    err_count_r <= CNT_ONE;
                end else if (err_count_r != CNT_MAX) begin
                    err_count_r <= err_count_r + CNT_ONE;
                end
            end else if (bus.err_clr) begin
                err_sticky_r <= 1'b0;
                err_count_r  <= '0;
            end
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_err    = out_err_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.err_count  = err_count_r;
endmodule

// File: tb/tb_parity_checker.sv
// Directed bench: an even-parity checker with a 2-bit counter and an odd-parity checker
// with an 8-bit counter, driven with identical stimulus.
module tb_parity_checker;
    logic clk;
    logic rst;

    parity_checker_if #(.WIDTH(8), .CNT_WIDTH(2)) be ();
    parity_checker_if #(.WIDTH(8), .CNT_WIDTH(8)) bo ();

    parity_checker #(.WIDTH(8), .ODD(0), .CNT_WIDTH(2)) dut_e (.clk(clk), .rst(rst), .bus(be));
    parity_checker #(.WIDTH(8), .ODD(1), .CNT_WIDTH(8)) dut_o (.clk(clk), .rst(rst), .bus(bo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       e_err;
        logic       o_err;
        logic [1:0] e_cnt;
        logic [7:0] o_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic p,
                         input logic ordy, input logic clr);
        be.in_valid = v;  be.in_data = d;  be.in_parity = p;  be.out_ready = ordy;  be.err_clr = clr;
        bo.in_valid = v;  bo.in_data = d;  bo.in_parity = p;  bo.out_ready = ordy;  bo.err_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sat_exp[5];
        logic [7:0] rcv[$];
        logic [7:0] w;
        int         idx;
        int         cyc;
        logic       acc;

        vectors     = 0;
        miscompares = 0;
        sat_exp     = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        //                 data   par   e_err o_err e_cnt o_cnt
        tbl[0] = '{8'hAA, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
        tbl[1] = '{8'hAB, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'd2};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2'd2, 8'd2};
        tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 2'd2, 8'd3};
        tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 2'd3, 8'd3};
        tbl[6] = '{8'h7F, 1'b0, 1'b1, 1'b0, 2'd3, 8'd3};
        tbl[7] = '{8'h3C, 1'b1, 1'b1, 1'b0, 2'd3, 8'd3};

        // Reset with a word presented: it must be discarded.
        rst = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check("rst_out_valid", 64'(be.out_valid), 64'd0);
        check("rst_out_data", 64'(be.out_data), 64'd0);
        check("rst_out_err", 64'(be.out_err), 64'd0);
        check("rst_err_count", 64'(be.err_count), 64'd0);
        check("rst_err_sticky", 64'(be.err_sticky), 64'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        check("rst_in_ready", 64'(be.in_ready), 64'd1);
        step();
        check("rst_no_word", 64'(be.out_valid), 64'd0);

        // Streaming table, out_ready held high.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].data, tbl[i].par, 1'b1, 1'b0);
            #1;
            check($sformatf("tbl%0d_in_ready", i), 64'(be.in_ready), 64'd1);
            step();
            check($sformatf("tbl%0d_valid", i), 64'(be.out_valid), 64'd1);
            check($sformatf("tbl%0d_data", i), 64'(be.out_data), 64'(tbl[i].data));
            check($sformatf("tbl%0d_err_e", i), 64'(be.out_err), 64'(tbl[i].e_err));
            check($sformatf("tbl%0d_err_o", i), 64'(bo.out_err), 64'(tbl[i].o_err));
            check($sformatf("tbl%0d_cnt_e", i), 64'(be.err_count), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_cnt_o", i), 64'(bo.err_count), 64'(tbl[i].o_cnt));
            check($sformatf("tbl%0d_sticky_e", i), 64'(be.err_sticky), 64'(tbl[i].e_cnt != 2'd0));
        end

        // Clear coinciding with a mismatched accept while saturated.
        drive(1'b1, 8'hAB, 1'b0, 1'b1, 1'b1);
        step();
        check("clr_hit_cnt", 64'(be.err_count), 64'd1);
        check("clr_hit_sticky", 64'(be.err_sticky), 64'd1);

        // Clear alone during a stall: status clears, held output untouched.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        check("clr_cnt", 64'(be.err_count), 64'd0);
        check("clr_sticky", 64'(be.err_sticky), 64'd0);
        check("clr_hold_valid", 64'(be.out_valid), 64'd1);
        check("clr_hold_data", 64'(be.out_data), 64'hAB);
        check("clr_hold_err", 64'(be.out_err), 64'd1);

        // Drain with no new word.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        check("drain_valid", 64'(be.out_valid), 64'd0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0);
            step();
            check($sformatf("sat%0d_cnt", i), 64'(be.err_count), 64'(sat_exp[i]));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step();

        // Backpressure: 01..05, out_ready low for three cycles after the first word.
        idx = 0;
        for (cyc = 0; cyc < 20 && rcv.size() < 5; cyc++) begin
            w = 8'(idx + 1);
            drive(idx < 5, w, ^w, !(cyc >= 1 && cyc <= 3), 1'b0);
            #1;
            if (cyc >= 1 && cyc <= 3) begin
                check($sformatf("bp%0d_in_ready", cyc), 64'(be.in_ready), 64'd0);
                check($sformatf("bp%0d_hold", cyc), 64'(be.out_data), 64'h01);
            end
            acc = be.in_valid && be.in_ready;
            if (be.out_valid && be.out_ready) rcv.push_back(be.out_data);
            step();
            if (acc) idx++;
        end
        check("bp_count", 64'(rcv.size()), 64'd5);
        for (int i = 0; i < rcv.size() && i < 5; i++) begin
            check($sformatf("bp_word%0d", i), 64'(rcv[i]), 64'(i + 1));
        end

        // Reset while a mismatched word is held under backpressure.
        drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        step();
        check("rs_held_valid", 64'(be.out_valid), 64'd1);
        check("rs_held_sticky", 64'(be.err_sticky), 64'd1);
        rst = 1'b1;
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step();
        check("rs_valid", 64'(be.out_valid), 64'd0);
        check("rs_cnt", 64'(be.err_count), 64'd0);
        check("rs_sticky", 64'(be.err_sticky), 64'd0);
        check("rs_data", 64'(be.out_data), 64'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check("rs_in_ready", 64'(be.in_ready), 64'd1);
        step();
        check("rs_discard", 64'(be.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
